// File: rtl/traffic_conflict_monitor.sv
// traffic_conflict_monitor: registers controller lamps to the drivers, watches
// for conflicting right-of-way, illegal encodings and bad yellow sequencing,
// and on a fault latches a code and flashes red on both streets until cleared.

// Per-street sequence checker: previous valid sample and yellow dwell counter.
module tcm_street #(
  parameter logic [7:0] MIN_YELLOW = 8'd30
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       en,        // checks active (MONITOR)
  input  logic       clr,       // fault exit: back to reset history
  input  logic [2:0] lights,
  output logic       valid,
  output logic       skip,
  output logic       short_y
);
  logic [2:0] hist;
  logic [7:0] ycnt;

  // Legal encodings and sequence violations against the last valid sample
  always_comb begin
    valid   = (lights == 3'b100) || (lights == 3'b010) || (lights == 3'b001);
    skip    = valid && (hist == 3'b001) && (lights == 3'b100);
    short_y = (hist == 3'b010) && (lights == 3'b100) && (ycnt < MIN_YELLOW);
  end

  // History only follows valid samples; yellow counter clears on anything but yellow
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hist <= 3'b100;
      ycnt <= 8'd0;
    end else if (clr) begin
      hist <= 3'b100;
      ycnt <= 8'd0;
    end else if (en) begin
      if (lights == 3'b010) ycnt <= (ycnt == 8'hff) ? ycnt : ycnt + 8'd1;
      else                  ycnt <= 8'd0;
      if (valid) hist <= lights;
    end
  end
endmodule

module traffic_conflict_monitor #(
  parameter logic [7:0] FILTER_CYCLES = 8'd2,
  parameter logic [7:0] MIN_YELLOW    = 8'd30,
  parameter logic [7:0] FLASH_HALF    = 8'd50
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [2:0] main_lights,
  input  logic [2:0] side_lights,
  input  logic       fault_clear,
  output logic [2:0] main_out,
  output logic [2:0] side_out,
  output logic       fault,
  output logic [2:0] fault_code
);
  typedef enum logic {MONITOR = 1'b0, FLASH = 1'b1} state_t;

  localparam logic [7:0] FMAX = (FILTER_CYCLES == 8'd0) ? 8'd1 : FILTER_CYCLES;

  state_t          state, state_next;
  logic [1:0][2:0] lights;     // [1] main, [0] side
  logic [1:0]      valid, skip, short_y;
  logic            conflict, hazard, haz_latch, latch, exit_flash;
  logic [7:0]      filt, filt_inc, fcnt;
  logic            phase;
  logic [2:0]      code_win;

  assign lights = {main_lights, side_lights};

  for (genvar g = 0; g < 2; g++) begin : g_street
    tcm_street #(.MIN_YELLOW(MIN_YELLOW)) u_street (
      .clk     (clk),
      .reset_n (reset_n),
      .en      (state == MONITOR),
      .clr     (exit_flash),
      .lights  (lights[g]),
      .valid   (valid[g]),
      .skip    (skip[g]),
      .short_y (short_y[g])
    );
  end

  // Hazard detection, filter threshold and winning fault code
  always_comb begin
    conflict   = (|main_lights[1:0]) && (|side_lights[1:0]);
    hazard     = conflict || !(&valid);
    filt_inc   = (filt == 8'hff) ? filt : filt + 8'd1;
    haz_latch  = hazard && (filt_inc >= FMAX);
    latch      = haz_latch || (|skip) || (|short_y);
    exit_flash = (state == FLASH) && fault_clear && !hazard;
    if (conflict)       code_win = 3'd1;
    else if (!(&valid)) code_win = 3'd2;
    else if (|skip)     code_win = 3'd3;
    else                code_win = 3'd4;
  end

  // Next-state: latch into FLASH, leave on a clean clear request
  always_comb begin
    state_next = state;
    case (state)
      MONITOR: if (latch)      state_next = FLASH;
      FLASH:   if (exit_flash) state_next = MONITOR;
      default:                 state_next = MONITOR;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= MONITOR;
    else          state <= state_next;
  end

  assign fault = (state == FLASH);

  // Filter counter, fault code, flash timing and registered lamp drive
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      filt       <= 8'd0;
      fcnt       <= 8'd0;
      phase      <= 1'b1;
      fault_code <= 3'd0;
      main_out   <= 3'b100;
      side_out   <= 3'b100;
    end else if (state == MONITOR) begin
      filt <= hazard ? filt_inc : 8'd0;
      if (latch) begin
        fault_code <= code_win;
        phase      <= 1'b1;
        fcnt       <= 8'd0;
        main_out   <= 3'b100;
        side_out   <= 3'b100;
      end else if (hazard) begin
        // never pass a suspect pair through to the lamps
        main_out <= 3'b100;
        side_out <= 3'b100;
      end else begin
        main_out <= main_lights;
        side_out <= side_lights;
      end
    end else if (exit_flash) begin
      filt       <= 8'd0;
      fcnt       <= 8'd0;
      phase      <= 1'b1;
      fault_code <= 3'd0;
      main_out   <= 3'b100;
      side_out   <= 3'b100;
    end else if (fcnt == FLASH_HALF - 8'd1) begin
      fcnt     <= 8'd0;
      phase    <= ~phase;
      main_out <= {~phase, 2'b00};
      side_out <= {~phase, 2'b00};
    end else begin
      fcnt     <= fcnt + 8'd1;
      main_out <= {phase, 2'b00};
      side_out <= {phase, 2'b00};
    end
  end
endmodule

// File: tb/tb_traffic_conflict_monitor.sv
// Randomized plus directed bench for traffic_conflict_monitor with a
// rule-level reference model and a per-cycle compare process.
module tb_traffic_conflict_monitor;
  localparam int FILT = 2;
  localparam int MINY = 30;
  localparam int HALF = 50;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [2:0] main_lights = 3'b100, side_lights = 3'b100;
  logic       fault_clear = 1'b0;
  logic [2:0] main_out, side_out, fault_code;
  logic       fault;

  int n_tests = 0;
  int n_fail  = 0;

  traffic_conflict_monitor #(
    .FILTER_CYCLES(8'(FILT)), .MIN_YELLOW(8'(MINY)), .FLASH_HALF(8'(HALF))
  ) dut (
    .clk(clk), .reset_n(reset_n), .main_lights(main_lights), .side_lights(side_lights),
    .fault_clear(fault_clear), .main_out(main_out), .side_out(side_out),
    .fault(fault), .fault_code(fault_code)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  bit   m_flash;
  int   run, t_flash;
  int   yel[2], hist[2];
  int   em, es, ec;

  function automatic bit legal(int v);
    return (v == 4) || (v == 2) || (v == 1);
  endfunction

  always @(posedge clk or negedge reset_n) begin
    int lv[2];
    bit conf, haz, lat, any_skip, any_short, inv;
    int need;
    if (!reset_n) begin
      m_flash = 0; run = 0; t_flash = 0;
      yel[0] = 0; yel[1] = 0; hist[0] = 4; hist[1] = 4;
      em = 4; es = 4; ec = 0;
    end else begin
      lv[0] = int'(main_lights); lv[1] = int'(side_lights);
      conf = ((lv[0] & 3) != 0) && ((lv[1] & 3) != 0);
      inv  = !legal(lv[0]) || !legal(lv[1]);
      haz  = conf || inv;
      if (!m_flash) begin
        run  = haz ? ((run < 255) ? run + 1 : 255) : 0;
        need = (FILT < 1) ? 1 : FILT;
        lat  = haz && (run >= need);
        any_skip = 0; any_short = 0;
        for (int i = 0; i < 2; i++) begin
          if (legal(lv[i]) && hist[i] == 1 && lv[i] == 4) any_skip = 1;
          if (hist[i] == 2 && lv[i] == 4 && yel[i] < MINY) any_short = 1;
          yel[i] = (lv[i] == 2) ? ((yel[i] < 255) ? yel[i] + 1 : 255) : 0;
          if (legal(lv[i])) hist[i] = lv[i];
        end
        if (lat || any_skip || any_short) begin
          m_flash = 1; t_flash = 0; em = 4; es = 4;
          ec = conf ? 1 : inv ? 2 : any_skip ? 3 : 4;
        end else if (haz) begin
          em = 4; es = 4;
        end else begin
          em = lv[0]; es = lv[1];
        end
      end else if (fault_clear && !haz) begin
        m_flash = 0; ec = 0; run = 0; em = 4; es = 4;
        yel[0] = 0; yel[1] = 0; hist[0] = 4; hist[1] = 4;
      end else begin
        t_flash++;
        em = (((t_flash / HALF) % 2) == 0) ? 4 : 0;
        es = em;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    logic [9:0] act, exp_v;
    act   = {main_out, side_out, fault, fault_code};
    exp_v = {3'(em), 3'(es), m_flash, 3'(ec)};
    n_tests++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL model t=%0t main/side/fault/code got %b/%b/%b/%0d expected %b/%b/%b/%0d",
               $time, main_out, side_out, fault, fault_code, 3'(em), 3'(es), m_flash, ec);
    end
  end

  task automatic lit(input string name, input int act, input int exp_v);
    n_tests++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s t=%0t got %0d expected %0d", name, $time, act, exp_v);
    end
  endtask

  task automatic step(input logic [2:0] m, input logic [2:0] s, input logic c);
    main_lights = m; side_lights = s; fault_clear = c;
    @(negedge clk);
  endtask

  function automatic logic [2:0] pick(input logic [2:0] prev);
    int r;
    r = $urandom % 10;
    if (r < 3)      return 3'b100;
    else if (r < 6) return 3'b010;
    else if (r < 8) return 3'b001;
    else if (r < 9) return 3'($urandom);
    else            return prev;
  endfunction

  initial begin
    logic [2:0] rm, rs;
    int len;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    lit("reset_main", main_out, 4); lit("reset_side", side_out, 4);
    lit("reset_fault", fault, 0);   lit("reset_code", fault_code, 0);

    // legal cycle
    step(3'b001, 3'b100, 0); lit("pass_main_green", main_out, 1);
    repeat (3)  step(3'b001, 3'b100, 0);
    repeat (30) step(3'b010, 3'b100, 0);
    step(3'b100, 3'b100, 0); lit("full_yellow_ok", fault, 0);
    step(3'b100, 3'b001, 0); lit("pass_side_green", side_out, 1);
    repeat (3) step(3'b100, 3'b001, 0);

    // one-cycle conflict glitch (main green bit with invalid encoding)
    step(3'b011, 3'b001, 0); lit("glitch_forced", {main_out, side_out}, 6'o44);
    lit("glitch_nofault", fault, 0);
    step(3'b100, 3'b001, 0); lit("glitch_resume", {main_out, side_out}, 6'o41);
    lit("glitch_nofault2", fault, 0);

    // filtered conflict
    step(3'b001, 3'b001, 0); lit("conf_forced", {main_out, side_out}, 6'o44);
    lit("conf_pending", fault, 0);
    step(3'b001, 3'b001, 0); lit("conf_fault", fault, 1); lit("conf_code", fault_code, 1);
    step(3'b001, 3'b001, 1); lit("clear_blocked", fault, 1);
    step(3'b100, 3'b100, 1); lit("clear_ok", fault, 0); lit("clear_code", fault_code, 0);
    step(3'b100, 3'b100, 0);

    // skipped yellow and flash timing
    step(3'b001, 3'b100, 0); lit("skip_pre", main_out, 1);
    step(3'b100, 3'b100, 0); lit("skip_code", fault_code, 3); lit("skip_red", main_out, 4);
    repeat (49) step(3'b100, 3'b100, 0);
    lit("flash_red_end", main_out, 4);
    step(3'b100, 3'b100, 0); lit("flash_dark", main_out, 0);
    repeat (49) step(3'b100, 3'b100, 0);
    step(3'b100, 3'b100, 0); lit("flash_red_again", main_out, 4);

    // asynchronous reset mid-flash
    repeat (7) step(3'b100, 3'b100, 0);
    #2 reset_n = 1'b0;
    #1 lit("rst_mid_out", {main_out, side_out}, 6'o44); lit("rst_mid_fault", fault, 0);
    #1 reset_n = 1'b1;
    @(negedge clk);

    // short yellow
    repeat (10) step(3'b010, 3'b100, 0);
    step(3'b100, 3'b100, 0); lit("short_code", fault_code, 4);
    step(3'b100, 3'b100, 1);

    // invalid encoding
    step(3'b110, 3'b100, 0); lit("inv_pending", fault, 0);
    step(3'b110, 3'b100, 0); lit("inv_code", fault_code, 2);
    step(3'b100, 3'b100, 1);

    // invalid plus conflict: conflict wins
    step(3'b011, 3'b001, 0);
    step(3'b011, 3'b001, 0); lit("inv_conf_code", fault_code, 1);
    step(3'b100, 3'b100, 1);

    // randomized segments
    rm = 3'b100; rs = 3'b100;
    for (int seg = 0; seg < 300; seg++) begin
      len = $urandom_range(1, 40);
      rm = pick(rm);
      rs = ($urandom % 3 == 0) ? 3'b100 : pick(rs);
      for (int k = 0; k < len; k++)
        step(rm, rs, ($urandom % 4) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
